// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative multiplier and the ALU decode that drives it.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: magnitudes are multiplied over WIDTH cycles, then the
// sign is applied once in FIX. Latency is WIDTH+1 cycles from START to DONE.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] LOW,
  output logic [WIDTH-1:0] HIGH
);

  state_e               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;

  logic                 sgn_mode;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   product;

  // Magnitudes are WIDTH-bit unsigned, so the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    sgn_mode = (SIGNED == MODE_SIGNED);
    abs_a    = (sgn_mode && A[WIDTH-1]) ? -A : A;
    abs_b    = (sgn_mode && B[WIDTH-1]) ? -B : B;
    sum      = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    product  = {acc, mplier};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      LOW    <= '0;
      HIGH   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            mcand  <= abs_a;
            mplier <= abs_b;
            neg    <= sgn_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // {carry, acc, mplier} >> 1: the carry lands in acc's MSB.
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          {HIGH, LOW} <= neg ? -product : product;
          DONE        <= 1'b1;
          BUSY        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=32 (hand-computed vectors) and WIDTH=8 (model).
module tb_seq_multiplier;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, start32, s32, busy32, done32;
  logic [31:0] a32, b32, low32, high32;
  logic        rst8, start8, s8, busy8, done8;
  logic [7:0]  a8, b8, low8, high8;

  int total  = 0;
  int passed = 0;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .START(start32), .SIGNED(s32), .A(a32), .B(b32),
    .BUSY(busy32), .DONE(done32), .LOW(low32), .HIGH(high32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .START(start8), .SIGNED(s8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .LOW(low8), .HIGH(high8)
  );

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  // Caller is at a negedge; returns at the negedge inside the DONE cycle.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      output logic [31:0] hi, output logic [31:0] lo, output int lat);
    a32 = a; b32 = b; s32 = s; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hi = high32;
    lo = low32;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int lat);
    a8 = a; b8 = b; s8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = {high8, low8};
  endtask

  task automatic test_reset();
    rst32 = 1'b1; rst8 = 1'b1;
    start32 = 1'b0; start8 = 1'b0; s32 = 1'b0; s8 = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    total++;
    if ({busy32, done32, high32, low32} !== 66'd0)
      $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h want all zero",
               busy32, done32, high32, low32);
    else passed++;
    total++;
    if ({busy8, done8, high8, low8} !== 18'd0)
      $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h want all zero",
               busy8, done8, high8, low8);
    else passed++;
  endtask

  task automatic test_unsigned_signed();
    logic [31:0] hi, lo;
    int lat;
    @(negedge clk);
    op32(32'h00000002, 32'hFFFFFFFE, 1'b0, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFC)
      $display("FAIL u_2xfffe: got %h_%h want 00000001_fffffffc", hi, lo);
    else passed++;
    total++;
    if (lat !== 33) $display("FAIL latency32: got %0d want 33", lat);
    else passed++;
    total++;
    if (busy32 !== 1'b0) $display("FAIL busy_in_done: got %b want 0", busy32);
    else passed++;
    @(negedge clk);
    total++;
    if (done32 !== 1'b0) $display("FAIL done_pulse: got %b want 0", done32);
    else passed++;
    op32(32'h00000002, 32'hFFFFFFFE, 1'b1, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFC)
      $display("FAIL s_2xm2: got %h_%h want ffffffff_fffffffc", hi, lo);
    else passed++;
    @(negedge clk);
    op32(32'hFFFFFFFB, 32'h00000006, 1'b0, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'h00000005_FFFFFFE2)
      $display("FAIL u_fffbx6: got %h_%h want 00000005_ffffffe2", hi, lo);
    else passed++;
    @(negedge clk);
    op32(32'hFFFFFFFB, 32'h00000006, 1'b1, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFE2)
      $display("FAIL s_m5x6: got %h_%h want ffffffff_ffffffe2", hi, lo);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int lat;
    @(negedge clk);
    op32(32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'h00000000_0000001E)
      $display("FAIL s_m5xm6: got %h_%h want 00000000_0000001e", hi, lo);
    else passed++;
    // Second START issued inside the DONE cycle.
    op32(32'hFFFFFFFB, 32'hFFFFFFFA, 1'b0, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'hFFFFFFF5_0000001E)
      $display("FAIL b2b_u: got %h_%h want fffffff5_0000001e", hi, lo);
    else passed++;
    total++;
    if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat);
    else passed++;
  endtask

  task automatic test_most_negative();
    logic [31:0] hi, lo;
    int lat;
    @(negedge clk);
    op32(32'h80000000, 32'h80000000, 1'b1, hi, lo, lat);
    total++;
    if ({hi, lo} !== 64'h40000000_00000000)
      $display("FAIL s_minxmin: got %h_%h want 40000000_00000000", hi, lo);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    a32 = 32'd7; b32 = 32'd9; s32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    total++;
    if (busy32 !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy32);
    else passed++;
    repeat (10) @(negedge clk);
    a32 = 32'hDEADBEEF; b32 = 32'h12345678; s32 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    lat = 11;
    while (!done32 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if ({high32, low32} !== 64'd63)
      $display("FAIL ignore32: got %h_%h want 00000000_0000003f", high32, low32);
    else passed++;
    total++;
    if (lat !== 33) $display("FAIL ignore32_latency: got %0d want 33", lat);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int dones;
    @(negedge clk);
    a32 = 32'h00000003; b32 = 32'h00000005; s32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    total++;
    if ({busy32, done32, high32, low32} !== 66'd0)
      $display("FAIL rst_mid32: got busy=%b done=%b hi=%h lo=%h want all zero",
               busy32, done32, high32, low32);
    else passed++;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL rst_mid32_nodone: got %0d DONE pulses want 0", dones);
    else passed++;
  endtask

  task automatic test_w8_model();
    logic [7:0] va [6] = '{8'h80, 8'hFB, 8'hFB, 8'h7F, 8'h00, 8'hFF};
    logic [7:0] vb [6] = '{8'h80, 8'h06, 8'hFA, 8'h81, 8'h9C, 8'hFF};
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      logic s;
      a = (i < 6) ? va[i] : 8'($urandom);
      b = (i < 6) ? vb[i] : 8'($urandom);
      s = 1'(i);
      @(negedge clk);
      op8(a, b, s, p, lat);
      total++;
      if (p !== ref8(a, b, s) || lat !== 9)
        $display("FAIL w8_vec%0d: a=%h b=%h s=%b got %h lat %0d want %h lat 9",
                 i, a, b, s, p, lat, ref8(a, b, s));
      else passed++;
    end
  endtask

  task automatic test_w8_ignore_and_reset();
    int lat, dones;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; s8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if ({high8, low8} !== ref8(8'h80, 8'h80, 1'b1) || lat !== 9)
      $display("FAIL ignore8: got %h%h lat %0d want %h lat 9",
               high8, low8, lat, ref8(8'h80, 8'h80, 1'b1));
    else passed++;
    @(negedge clk);
    a8 = 8'h0D; b8 = 8'h0E; s8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    total++;
    if ({busy8, done8, high8, low8} !== 18'd0)
      $display("FAIL rst_mid8: got busy=%b done=%b hi=%h lo=%h want all zero",
               busy8, done8, high8, low8);
    else passed++;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL rst_mid8_nodone: got %0d DONE pulses want 0", dones);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned_signed();
    test_back_to_back();
    test_most_negative();
    test_start_ignored();
    test_reset_mid_run();
    test_w8_model();
    test_w8_ignore_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised, iterative shift-add multiplier producing a 2×WIDTH product as HIGH/LOW words, with selectable signed or unsigned operation. It replaces the single-cycle combinational unsigned multiplier in the ALU's multiply path. A START/DONE handshake lets the core stall on BUSY instead of closing timing on a full-width array multiplier.

## Interface
Parameters:
- WIDTH, 32: operand width; product is 2×WIDTH. Legal values are 4 to 64.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only while BUSY=0.
- SIGNED  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with START.
- A  in  WIDTH  multiplicand; sampled with START.
- B  in  WIDTH  multiplier; sampled with START.
- BUSY  out  1  high from the cycle after START is accepted until DONE is asserted.
- DONE  out  1  one-cycle pulse; HIGH/LOW are valid in that cycle.
- LOW  out  WIDTH  product bits [WIDTH-1:0]; held until the next DONE.
- HIGH  out  WIDTH  product bits [2WIDTH-1:WIDTH]; held until the next DONE.

## Operation
- FSM states:
  - IDLE: wait for START.
  - RUN: WIDTH iterations.
  - FIX: sign correction and output register load.
- IDLE, START=1 → RUN. Capture the following:
  - mcand = |A| if SIGNED else A.
  - mplier = |B| if SIGNED else B.
  - neg = SIGNED & (A[msb] ^ B[msb]).
  - acc = 0, cnt = 0.
- |x| is computed as a WIDTH-bit unsigned value, so the most negative input maps to 2^(WIDTH-1) without overflow.
- RUN, each cycle:
  - If mplier[0] is set, add mcand to acc[2W-1:W] with carry-out retained.
  - Shift {carry, acc, mplier} right by one.
  - cnt++.
  - When cnt = WIDTH-1, go to FIX.
- FIX: {HIGH, LOW} ← neg ? -product : product, taken modulo 2^(2W). Assert DONE next cycle, then go to IDLE.
- START while BUSY=1 is ignored; operands are not re-sampled.
- START during the DONE cycle is accepted, because the FSM is already in IDLE. This gives back-to-back operation.
- A zero operand still takes the full latency; there is no early termination.
- Unsigned results match {HIGH, LOW} = A×B exactly. Signed results are the exact two's-complement 2W-bit product.

## Timing
- START sampled at edge k:
  - BUSY = 1 from edge k to edge k+WIDTH+1.
  - HIGH/LOW update and DONE = 1 at edge k+WIDTH+1.
  - DONE deasserts at edge k+WIDTH+2.
- Total latency is WIDTH+1 cycles, i.e. 33 for WIDTH=32. Throughput is one product per WIDTH+1 cycles.
- Reset values:
  - State = IDLE.
  - BUSY = 0, DONE = 0, LOW = 0, HIGH = 0.
  - Internal acc, cnt and neg = 0.
- rst asserted mid-operation aborts the operation. All of the above return to reset values on that edge, and no DONE is produced. rst has priority over START.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Structure
- Shared package mult_pkg holds:
  - The state typedef (IDLE, RUN, FIX).
  - MODE_UNSIGNED = 1'b0 and MODE_SIGNED = 1'b1 constants, for reuse by the ALU decode.
- The design is a single module. The datapath (abs, add/shift, negate) is small enough that a sub-module is not warranted.

## Test plan
- WIDTH=32, unsigned: A=0x00000002, B=0xFFFFFFFE → HIGH=0x00000001, LOW=0xFFFFFFFC. DONE arrives exactly 33 cycles after START.
- Same operands, signed → HIGH=0xFFFFFFFF, LOW=0xFFFFFFFC.
- A=0xFFFFFFFB, B=0x00000006:
  - Unsigned → HIGH=0x00000005, LOW=0xFFFFFFE2.
  - Signed → HIGH=0xFFFFFFFF, LOW=0xFFFFFFE2.
- A=0xFFFFFFFB, B=0xFFFFFFFA:
  - Signed → HIGH=0, LOW=0x0000001E.
  - Unsigned → HIGH=0xFFFFFFF5, LOW=0x0000001E.
  - Run these back-to-back, with the second START in the DONE cycle; the second DONE arrives 33 cycles later.
- Corner cases:
  - Signed A=B=0x80000000 → HIGH=0x40000000, LOW=0.
  - START with different operands pulsed mid-RUN is ignored, and the result is unchanged.
- Reset mid-RUN (cycle 10): BUSY=DONE=HIGH=LOW=0 the next cycle, and no DONE follows. Repeat the last two cases at WIDTH=8 against a reference model.
